// File: rtl/multi_channel_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_channel_clock_divider
//
// N independent programmable clock dividers. Each channel counts system clocks
// up to its active half-period H. On reaching H it toggles its square-wave
// output and pulses tick, which gives an output period of 2*(H+1) clocks at an
// exact 50% duty cycle.
//
// Half-period updates come in two kinds:
//   - deferred (wr_sync=0): the value is parked in a pending register. It
//     becomes active at the next wrap, so the half-cycle already in progress
//     finishes at the old length and the output never glitches.
//   - hard restart (wr_sync=1): the value takes effect at once. The counter
//     clears and the output returns to RESET_LEVEL.
// A channel that is disabled, or whose active half-period is 0 (muted), holds
// its counter at 0 and its output at RESET_LEVEL. A pending value is applied
// immediately while a channel is idle, so a nonzero write unmutes it.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : asynchronous active-low reset (release expected synchronous)
//   wr_en    : one-cycle half-period write strobe
//   wr_chan  : write target channel; out-of-range targets are ignored
//   wr_half  : new half-period value
//   wr_sync  : 1 = hard restart, 0 = deferred to next wrap
//   ch_en    : per-channel enable level
//   clk_out  : per-channel divided square wave (registered)
//   tick     : per-channel one-cycle pulse on each clk_out toggle (registered)
// -----------------------------------------------------------------------------
module multi_channel_clock_divider #(
  parameter int   CHANNELS     = 4,
  parameter int   CNT_W        = 21,
  parameter int   DEFAULT_HALF = 900000,
  parameter logic RESET_LEVEL  = 1'b1,
  localparam int  CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [CNT_W-1:0]    wr_half,
  input  logic                wr_sync,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             running;
    logic             wrap;

    // An out-of-range wr_chan matches no channel, so the write is dropped.
    assign wr_hit  = wr_en && (wr_chan == CH_W'(i));
    assign running = ch_en[i] && (active_half != '0);
    assign wrap    = (cnt == active_half);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt         <= '0;
        active_half <= DEF_HALF;
        pend_half   <= DEF_HALF;
        pend_valid  <= 1'b0;
        clk_q       <= RESET_LEVEL;
        tick_q      <= 1'b0;
      end else if (wr_hit && wr_sync) begin
        // A hard restart overrides everything else this cycle, including a
        // wrap that would otherwise have produced a tick.
        active_half <= wr_half;
        cnt         <= '0;
        clk_q       <= RESET_LEVEL;
        tick_q      <= 1'b0;
        pend_valid  <= 1'b0;
      end else begin
        if (!running) begin
          cnt    <= '0;
          clk_q  <= RESET_LEVEL;
          tick_q <= 1'b0;
          if (pend_valid) begin
            active_half <= pend_half;
            pend_valid  <= 1'b0;
          end
        end else if (wrap) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= 1'b1;
          if (pend_valid) begin
            active_half <= pend_half;
            pend_valid  <= 1'b0;
          end
        end else begin
          cnt    <= cnt + 1'b1;
          tick_q <= 1'b0;
        end
        // A deferred write is placed last so that it wins over the promotion
        // above. The old pending value is promoted, and the new one waits for
        // the following wrap.
        if (wr_hit) begin
          pend_half  <= wr_half;
          pend_valid <= 1'b1;
        end
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
module tb_multi_channel_clock_divider;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic       wr_en_b;
  logic [1:0] wr_chan;
  logic [7:0] wr_half;
  logic       wr_sync;
  logic [3:0] ch_en;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [2:0] ch_en_b;
  logic [2:0] clk_out_b;
  logic [2:0] tick_b;

  int n_checks = 0;
  int n_fail   = 0;

  multi_channel_clock_divider #(
    .CHANNELS(4), .CNT_W(8), .DEFAULT_HALF(3), .RESET_LEVEL(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_half(wr_half), .wr_sync(wr_sync), .ch_en(ch_en),
    .clk_out(clk_out), .tick(tick)
  );

  // Three-channel build: wr_chan=3 is out of range here.
  multi_channel_clock_divider #(
    .CHANNELS(3), .CNT_W(8), .DEFAULT_HALF(3), .RESET_LEVEL(1'b1)
  ) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en_b), .wr_chan(wr_chan),
    .wr_half(wr_half), .wr_sync(wr_sync), .ch_en(ch_en_b),
    .clk_out(clk_out_b), .tick(tick_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset;
    #12;
    n_checks++;
    if ({clk_out, tick} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL reset_a got=%b exp=%b", {clk_out, tick}, 8'b1111_0000);
    end
    n_checks++;
    if ({clk_out_b, tick_b} !== 6'b111_000) begin
      n_fail++;
      $display("FAIL reset_b got=%b exp=%b", {clk_out_b, tick_b}, 6'b111_000);
    end
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // H=3 on channel 0: toggle every 4 cycles, others idle at 1.
  task automatic test_basic;
    logic [7:0] exp;
    ch_en = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clock); #1;
      exp = {3'b111, (((k / 4) % 2) == 0) ? 1'b1 : 1'b0,
             3'b000, ((k % 4) == 0) ? 1'b1 : 1'b0};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL basic k=%0d got=%b exp=%b", k, {clk_out, tick}, exp);
      end
    end
  endtask

  // Deferred H=1 on ch0 written at cnt=1: old half finishes, then period 4.
  task automatic test_deferred;
    logic [7:0] exp;
    logic       c0;
    logic       t0;
    @(posedge clock); #1;
    n_checks++;
    if ({clk_out, tick} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL deferred_pre got=%b exp=%b", {clk_out, tick}, 8'b1111_0000);
    end
    wr_en = 1'b1; wr_chan = 2'd0; wr_half = 8'd1; wr_sync = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      @(posedge clock); #1;
      wr_en = 1'b0;
      t0 = (j >= 3) && (((j - 3) % 2) == 0);
      c0 = (j < 3) ? 1'b1 : ((((j - 3) / 2) % 2) != 0);
      exp = {3'b111, c0, 3'b000, t0};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL deferred j=%0d got=%b exp=%b", j, {clk_out, tick}, exp);
      end
    end
  endtask

  // Sync restart of ch2 with H=5 while ch0 keeps running at H=1.
  task automatic test_sync;
    logic [7:0] exp;
    logic       c0, t0, c2, t2;
    ch_en = 4'b0101;
    for (int m = 1; m <= 12; m++) begin
      @(posedge clock); #1;
      t0 = ((m % 2) == 0);
      c0 = (((m / 2) % 2) == 0);
      if (m <= 5) begin
        t2 = (m == 4);
        c2 = (m < 4);
      end else begin
        t2 = (m == 12);
        c2 = (m != 12);
      end
      exp = {1'b1, c2, 1'b1, c0, 1'b0, t2, 1'b0, t0};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL sync m=%0d got=%b exp=%b", m, {clk_out, tick}, exp);
      end
      if (m == 5) begin
        wr_en = 1'b1; wr_chan = 2'd2; wr_half = 8'd5; wr_sync = 1'b1;
      end
      if (m == 6) begin
        wr_en = 1'b0; wr_sync = 1'b0;
      end
    end
  endtask

  // Mute ch1 with H=0, then unmute with deferred H=2.
  task automatic test_mute;
    logic [7:0] exp;
    logic       c1, t1;
    ch_en = 4'b0010;
    wr_en = 1'b1; wr_chan = 2'd1; wr_half = 8'd0; wr_sync = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clock); #1;
      if (n < 11) begin
        c1 = 1'b1;
        t1 = 1'b0;
      end else begin
        t1 = (((n - 11) % 3) == 0);
        c1 = ((((n - 11) / 3) % 2) != 0);
      end
      exp = {2'b11, c1, 1'b1, 2'b00, t1, 1'b0};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL mute n=%0d got=%b exp=%b", n, {clk_out, tick}, exp);
      end
      if (n == 1) begin
        wr_en = 1'b0; wr_sync = 1'b0;
      end
      if (n == 6) begin
        wr_en = 1'b1; wr_chan = 2'd1; wr_half = 8'd2; wr_sync = 1'b0;
      end
      if (n == 7) wr_en = 1'b0;
    end
  endtask

  // Three-channel build: writes to wr_chan=3 must leave every channel alone.
  task automatic test_invalid;
    logic [5:0] exp;
    ch_en_b = 3'b111;
    for (int p = 1; p <= 16; p++) begin
      @(posedge clock); #1;
      exp = {(((p / 4) % 2) == 0) ? 3'b111 : 3'b000,
             ((p % 4) == 0) ? 3'b111 : 3'b000};
      n_checks++;
      if ({clk_out_b, tick_b} !== exp) begin
        n_fail++;
        $display("FAIL invalid p=%0d got=%b exp=%b", p, {clk_out_b, tick_b}, exp);
      end
      if (p == 1) begin
        wr_en_b = 1'b1; wr_chan = 2'd3; wr_half = 8'd1; wr_sync = 1'b1;
      end
      if (p == 2) begin
        wr_en_b = 1'b0; wr_sync = 1'b0;
      end
      if (p == 8) begin
        wr_en_b = 1'b1; wr_chan = 2'd3; wr_half = 8'd0; wr_sync = 1'b0;
      end
      if (p == 9) wr_en_b = 1'b0;
    end
  endtask

  // Deferred write landing on a ch0 wrap while an older pend is valid.
  task automatic test_wrap_collision;
    logic [7:0] exp;
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    exp_clk  = 8'b1111_0001;
    exp_tick = 8'b0001_0010;
    ch_en = 4'b0001;
    wr_en = 1'b1; wr_chan = 2'd0; wr_half = 8'd2; wr_sync = 1'b0;
    for (int q = 1; q <= 8; q++) begin
      @(posedge clock); #1;
      exp = {3'b111, exp_clk[q-1], 3'b000, exp_tick[q-1]};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL collision q=%0d got=%b exp=%b", q, {clk_out, tick}, exp);
      end
      if (q == 1) wr_half = 8'd3;
      if (q == 2) wr_en = 1'b0;
    end
  endtask

  // Reset mid-run with a pending write outstanding.
  task automatic test_reset_mid;
    logic [7:0] exp;
    logic [5:0] exp_b;
    wr_en = 1'b1; wr_chan = 2'd0; wr_half = 8'd1; wr_sync = 1'b0;
    @(posedge clock); #1;
    wr_en = 1'b0;
    n_checks++;
    if ({clk_out[0], tick[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid_pre got=%b exp=%b", {clk_out[0], tick[0]}, 2'b01);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({clk_out, tick} !== 8'b1111_0000) begin
      n_fail++;
      $display("FAIL rstmid_async got=%b exp=%b", {clk_out, tick}, 8'b1111_0000);
    end
    n_checks++;
    if ({clk_out_b, tick_b} !== 6'b111_000) begin
      n_fail++;
      $display("FAIL rstmid_async_b got=%b exp=%b", {clk_out_b, tick_b}, 6'b111_000);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      @(posedge clock); #1;
      exp = {3'b111, (((r / 4) % 2) == 0) ? 1'b1 : 1'b0,
             3'b000, ((r % 4) == 0) ? 1'b1 : 1'b0};
      exp_b = {(((r / 4) % 2) == 0) ? 3'b111 : 3'b000,
               ((r % 4) == 0) ? 3'b111 : 3'b000};
      n_checks++;
      if ({clk_out, tick} !== exp) begin
        n_fail++;
        $display("FAIL rstmid_after r=%0d got=%b exp=%b", r, {clk_out, tick}, exp);
      end
      n_checks++;
      if ({clk_out_b, tick_b} !== exp_b) begin
        n_fail++;
        $display("FAIL rstmid_after_b r=%0d got=%b exp=%b", r, {clk_out_b, tick_b}, exp_b);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_en_b = 1'b0;
    wr_chan = 2'd0;
    wr_half = 8'd0;
    wr_sync = 1'b0;
    ch_en   = 4'b0000;
    ch_en_b = 3'b000;
    test_reset();
    test_basic();
    test_deferred();
    test_sync();
    test_mute();
    test_invalid();
    test_wrap_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_clock_divider.md
Name: multi_channel_clock_divider

Overview:
- Parametrised N-channel programmable clock divider. It replaces fixed-constant single dividers in the tone/timing path.
- Each channel produces a square wave and a one-cycle tick. Both derive from a per-channel half-period register that is writable at run time.
- Period updates are glitch-free (applied at the next wrap) unless a hard restart is requested.
- Sits between the system clock and the note/tempo generators.

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- CNT_W, 21, width of the per-channel counter and half-period registers.
- DEFAULT_HALF, 900000, reset value of every channel's active and pending half-period. Must fit in CNT_W.
- RESET_LEVEL, 1, level driven on clk_out after reset, while disabled, and while muted.
- CH_W (local), max(1, clog2(CHANNELS)), width of the channel select.

Ports:
- clock, in, 1, system clock. All logic is on the rising edge.
- reset, in, 1, asynchronous, active-low reset. Assertion takes effect immediately. Release is synchronous to clock.
- wr_en, in, 1, one-cycle write strobe for a half-period update.
- wr_chan, in, CH_W, target channel of the write.
- wr_half, in, CNT_W, new half-period value H.
- wr_sync, in, 1, qualifies wr_en. 1 = hard restart now; 0 = deferred to next wrap.
- ch_en, in, CHANNELS, per-channel enable (level).
- clk_out, out, CHANNELS, per-channel divided square wave (registered).
- tick, out, CHANNELS, one-cycle pulse on the cycle clk_out[i] toggles (registered).

Behaviour:
- Per-channel state:
  - cnt[CNT_W]
  - active_half[CNT_W]
  - pend_half[CNT_W]
  - pend_valid
- Reset (reset=0, asynchronous):
  - cnt=0
  - active_half=pend_half=DEFAULT_HALF
  - pend_valid=0
  - clk_out=all RESET_LEVEL
  - tick=0
- Run condition: ch_en[i]=1 and active_half[i]!=0.
  - cnt==active_half → cnt<=0, clk_out[i] toggles, tick[i]<=1. If pend_valid: active_half<=pend_half, pend_valid<=0.
  - Otherwise → cnt<=cnt+1, tick[i]<=0.
  - Output period = 2*(H+1) clocks. Duty is exactly 50%.
- Disabled (ch_en[i]=0):
  - cnt<=0, clk_out[i]<=RESET_LEVEL, tick[i]<=0.
  - A valid pending value is applied immediately.
  - On re-enable, the first toggle occurs H+1 cycles after the first enabled edge.
- Muted (active_half[i]==0, enabled):
  - Same as disabled: cnt held 0, clk_out=RESET_LEVEL, tick=0.
  - Pending is applied immediately, so a nonzero write unmutes on the next cycle.
- Deferred write (wr_en=1, wr_sync=0, wr_chan<CHANNELS):
  - pend_half<=wr_half, pend_valid<=1.
  - The current half-cycle completes at the old H.
- Hard restart (wr_en=1, wr_sync=1, wr_chan<CHANNELS):
  - active_half<=wr_half, cnt<=0, clk_out<=RESET_LEVEL, tick<=0, pend_valid<=0.
  - The first toggle follows H+1 cycles later.
- Invalid target: wr_chan>=CHANNELS → write ignored, no state change.
- Write and wrap on the same channel in the same cycle:
  - Deferred write: wrap promotes the old pend (if valid). The new value lands in pend_half with pend_valid=1.
  - Hard restart: the restart wins completely and no tick is emitted.
- Writes to other channels never disturb a channel's counter.
- cnt never exceeds active_half:
  - Deferred updates only apply at cnt=0.
  - Sync updates clear cnt.
- No wrap-around of cnt is possible.
- Reset mid-operation: all state returns to reset values in the same instant, and pending writes are lost.

Test Plan:
Bench configuration: CHANNELS=4, CNT_W=8, DEFAULT_HALF=3, RESET_LEVEL=1.
1. Reset, then ch_en=4'b0001 → clk_out[0] toggles every 4 cycles (period 8). tick[0] is high 1 cycle at each toggle. Channels 1–3 stay at 1 with tick=0.
2. Deferred write ch0 H=1 at cnt=1 → the current half still lasts 4 cycles, then the period becomes 4 (toggle every 2). pend_valid clears at the wrap.
3. Sync write ch2 H=5 while running → same cycle+1: clk_out[2]=1, cnt=0. The first toggle comes 6 cycles later. ch0 is unaffected.
4. Write ch1 H=0 → ch1 mutes (clk_out=1, no ticks). A later deferred write H=2 → resumes, toggling every 3 cycles.
5. wr_chan=3 is valid; with CHANNELS=3 build, wr_chan=3 → no change on any channel. Deferred write coinciding with a ch0 wrap → the old pend is promoted and the new value is applied on the following wrap.
6. Drop reset mid-count with pending writes outstanding → outputs go to RESET_LEVEL asynchronously and ticks go to 0. After release, the period is again 8 (DEFAULT_HALF restored, pending lost).
